differentiator: RTL and testbench
=================================

DIFFERENTIATOR -- requirements
Module: differentiator

Interface
REQ-001 Parameter AW, default 20: width of recovered sample A (signed).
REQ-002 Parameter PW, default 38: width of running-sum input P (signed).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 subtract_i  input  1  0: A = P[n]-P[n-1]; 1: A = P[n-1]-P[n]; sampled with valid_i.
REQ-006 valid_i  input  1  P valid this cycle.
REQ-007 flush_i  input  1  drop stored reference, return to unprimed state.
REQ-008 P  input  PW  signed running sum, e.g. from accumulator.
REQ-009 valid_o  output  1  A and ovf_o valid; single-cycle pulse per produced sample.
REQ-010 A  output  AW  signed recovered increment.
REQ-011 ovf_o  output  1  difference exceeded signed AW range for this sample.
REQ-012 primed_o  output  1  reference sample held (state RUN).

Function
REQ-013 Two states, UNPRIMED and RUN; encoding implementation-defined; state observable via primed_o.
REQ-014 UNPRIMED with valid_i=1: store P in prev, go to RUN, no output (valid_o=0 next cycle).
REQ-015 RUN with valid_i=1: compute d = P-prev (subtract_i=0) or prev-P (subtract_i=1) modulo 2^PW, store P in prev.
REQ-016 Latency exactly 1 cycle: valid_o=1 on cycle after accepted RUN sample; throughput one sample per cycle, no stalls.
REQ-017 valid_o=0 in any cycle following valid_i=0; A and ovf_o hold last values when valid_o=0.
REQ-018 Range check: d interpreted as signed PW; ovf_o=1 when d < -2^(AW-1) or d > 2^(AW-1)-1, else 0.
REQ-019 P wrap across 2^PW boundary is not overflow: modular subtraction recovers the increment exactly.
REQ-020 subtract_i may change on any sample; it applies only to the sample it accompanies.
REQ-021 flush_i=1, valid_i=0: go to UNPRIMED, no output next cycle.
REQ-022 flush_i=1 with valid_i=1: flush wins for difference, P stored as new prev, state RUN, no output next cycle.
REQ-023 flush_i while UNPRIMED: no effect beyond REQ-022 behaviour.

Reset
REQ-024 reset=0 at rising clk: state UNPRIMED, prev=0, valid_o=0, A=0, ovf_o=0, primed_o=0.
REQ-025 Reset overrides valid_i and flush_i in the same cycle; in-flight sample discarded.
REQ-026 First sample after reset release only primes (REQ-014).

Configuration
REQ-027 Macro DIFFERENTIATOR_SAT_EN defined: on ovf, A clamps to 2^(AW-1)-1 (d>0) or -2^(AW-1) (d<0).
REQ-028 Macro DIFFERENTIATOR_SAT_EN undefined: A = low AW bits of d (wrap); ovf_o still reported per REQ-018.

Verification
REQ-029 reset=0 for 2 cycles with valid_i=1 -> valid_o=0, A=0, ovf_o=0, primed_o=0.
REQ-030 subtract_i=0, P=0,5,10,10 back-to-back -> valid_o pulses 3 times, A=5,5,0, ovf_o=0, 1-cycle latency.
REQ-031 subtract_i=1, P=0,-5,-12 -> A=5,7; then subtract_i=0, P=-2 -> A=10.
REQ-032 P=100 then 100+2^20 -> ovf_o=1; A=524287 with SAT_EN, A=0 without.
REQ-033 P=2^37-1 then -2^37 -> A=1, ovf_o=0 (PW wrap).
REQ-034 P=7, flush_i+valid_i P=50, then P=53 -> no output for 50, A=3; reset mid-stream then P=9 -> no output, primed_o=1.

Source files
------------

// File: rtl/differentiator.sv
// rtl/differentiator.sv - recovers per-sample increments from a signed running sum
// Optional feature: define DIFFERENTIATOR_SAT_EN to clamp A on overflow instead of wrapping.
module differentiator #(
  parameter int AW = 20,
  parameter int PW = 38
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 subtract_i,
  input  logic                 valid_i,
  input  logic                 flush_i,
  input  logic signed [PW-1:0] P,
  output logic                 valid_o,
  output logic signed [AW-1:0] A,
  output logic                 ovf_o,
  output logic                 primed_o
);

  typedef enum logic {UNPRIMED = 1'b0, RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [PW-1:0]  r_prev;
  logic                  r_valid;
  logic signed [AW-1:0]  r_a;
  logic                  r_ovf;

  logic                  w_emit;
  logic        [PW-1:0]  w_diff;
  logic        [PW-AW:0] w_upper;
  logic                  w_ovf;
  logic signed [AW-1:0]  w_a;

  // Next state and emit decision; flush always discards the pending difference
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    if (flush_i) begin
      w_state_nxt = valid_i ? RUN : UNPRIMED;
    end else if (valid_i) begin
      w_state_nxt = RUN;
      w_emit      = (r_state == RUN);
    end
  end

  // Modular difference and signed-range check; bits above AW-1 must all equal the AW-1 sign bit
  always_comb begin
    w_diff  = subtract_i ? (r_prev - P) : (P - r_prev);
    w_upper = w_diff[PW-1:AW-1];
    w_ovf   = !((&w_upper) || (~|w_upper));
`ifdef DIFFERENTIATOR_SAT_EN
    if (w_ovf) begin
      w_a = w_diff[PW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      w_a = w_diff[AW-1:0];
    end
`else
    w_a = w_diff[AW-1:0];
`endif
  end

  // State, reference sample and registered outputs; A/ovf hold between pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= UNPRIMED;
      r_prev  <= '0;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_emit;
      if (valid_i) begin
        r_prev <= P;
      end
      if (w_emit) begin
        r_a   <= w_a;
        r_ovf <= w_ovf;
      end
    end
  end

  assign valid_o  = r_valid;
  assign A        = r_a;
  assign ovf_o    = r_ovf;
  assign primed_o = (r_state == RUN);

endmodule

// File: tb/tb_differentiator.sv
// tb/tb_differentiator.sv - scoreboard bench for differentiator with directed vectors
module tb_differentiator;

  localparam int AW = 20;
  localparam int PW = 38;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 subtract_i;
  logic                 valid_i;
  logic                 flush_i;
  logic signed [PW-1:0] P;
  logic                 valid_o;
  logic signed [AW-1:0] A;
  logic                 ovf_o;
  logic                 primed_o;

  differentiator #(.AW(AW), .PW(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .subtract_i (subtract_i),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .P          (P),
    .valid_o    (valid_o),
    .A          (A),
    .ovf_o      (ovf_o),
    .primed_o   (primed_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [AW-1:0] a;
    logic                 ovf;
    int                   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;

  localparam logic signed [PW-1:0] P_MAX  = (38'sd1 <<< 37) - 38'sd1;
  localparam logic signed [PW-1:0] P_MIN  = -(38'sd1 <<< 37);
  localparam logic signed [PW-1:0] P_2_19 = 38'sd1 <<< 19;
  localparam logic signed [PW-1:0] P_2_20 = 38'sd1 <<< 20;
  localparam logic signed [PW-1:0] P_NEG_EDGE = P_MIN + P_2_19 - 38'sd524289;

`ifdef DIFFERENTIATOR_SAT_EN
  localparam logic signed [AW-1:0] A_POS_OVF = 20'sd524287;
  localparam logic signed [AW-1:0] A_NEG_OVF = -20'sd524288;
`else
  localparam logic signed [AW-1:0] A_POS_OVF = 20'sd0;
  localparam logic signed [AW-1:0] A_NEG_OVF = 20'sd524287;
`endif

  always @(posedge clk) cyc++;

  // Monitor: every output pulse must match the oldest expectation, exactly one cycle after issue
  always @(negedge clk) begin
    if (mon_en && valid_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got A=%0d ovf=%0b, required no output", A, ovf_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (A !== e.a || ovf_o !== e.ovf || cyc != e.cyc + 1) begin
          n_fail++;
          $display("FAIL sample: got A=%0d ovf=%0b cyc=%0d, required A=%0d ovf=%0b cyc=%0d",
                   A, ovf_o, cyc, e.a, e.ovf, e.cyc + 1);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus; optionally push the expected result
  task automatic send(input logic signed [PW-1:0] p, input logic sub, input logic fl,
                      input logic v, input logic want, input logic signed [AW-1:0] ea,
                      input logic eovf);
    exp_t e;
    P          = p;
    subtract_i = sub;
    flush_i    = fl;
    valid_i    = v;
    if (want) begin
      e.a   = ea;
      e.ovf = eovf;
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    send('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; valid_i = 1'b1; flush_i = 1'b0; subtract_i = 1'b0; P = 38'sd123;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_valid_o", valid_o, 0);
    chk("reset_A", A, 0);
    chk("reset_ovf", ovf_o, 0);
    chk("reset_primed", primed_o, 0);
    mon_en = 1'b1;
    reset  = 1'b1;

    // Back-to-back accumulation
    send(38'sd0,  0, 0, 1, 0, '0, 0);
    chk("primed_after_first", primed_o, 1);
    send(38'sd5,  0, 0, 1, 1, 20'sd5, 0);
    send(38'sd10, 0, 0, 1, 1, 20'sd5, 0);
    send(38'sd10, 0, 0, 1, 1, 20'sd0, 0);
    idle();
    idle();
    chk("valid_drops", valid_o, 0);

    // Subtract mode toggled per sample
    send(38'sd0,   0, 1, 1, 0, '0, 0);
    send(-38'sd5,  1, 0, 1, 1, 20'sd5, 0);
    send(-38'sd12, 1, 0, 1, 1, 20'sd7, 0);
    send(-38'sd2,  0, 0, 1, 1, 20'sd10, 0);
    idle();
    idle();
    chk("A_holds", A, 10);

    // Positive overflow, then normal increment
    send(38'sd100, 0, 1, 1, 0, '0, 0);
    send(38'sd100 + P_2_20, 0, 0, 1, 1, A_POS_OVF, 1);
    send(38'sd103 + P_2_20, 0, 0, 1, 1, 20'sd3, 0);

    // Wrap across the PW boundary and the signed AW range edges
    send(P_MAX, 0, 1, 1, 0, '0, 0);
    send(P_MIN, 0, 0, 1, 1, 20'sd1, 0);
    send(P_MIN + P_2_19, 1, 0, 1, 1, -20'sd524288, 0);
    send(P_NEG_EDGE, 0, 0, 1, 1, A_NEG_OVF, 1);
    send(P_NEG_EDGE + 38'sd524287, 0, 0, 1, 1, 20'sd524287, 0);
    idle();
    chk("ovf_holds", ovf_o, 0);

    // Flush alone unprimes; flush with valid re-primes without output
    send('0, 0, 1, 0, 0, '0, 0);
    chk("flush_unprimes", primed_o, 0);
    send(38'sd7,  0, 0, 1, 0, '0, 0);
    send(38'sd50, 0, 1, 1, 0, '0, 0);
    chk("flush_valid_primed", primed_o, 1);
    send(38'sd53, 0, 0, 1, 1, 20'sd3, 0);

    // Reset mid-stream discards the in-flight sample
    reset = 1'b0;
    send(38'sd60, 0, 0, 1, 0, '0, 0);
    chk("midreset_primed", primed_o, 0);
    chk("midreset_valid", valid_o, 0);
    chk("midreset_A", A, 0);
    reset = 1'b1;
    send(38'sd9, 0, 0, 1, 0, '0, 0);
    chk("after_reset_primed", primed_o, 1);
    send(38'sd4, 0, 0, 1, 1, -20'sd5, 0);
    idle();
    idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end

endmodule
